// File: rtl/mem_arbiter_ctrl_if.sv
// Client, RAM-port and status signals of the byte-serial RAM arbiter.
// The master side is the surrounding system (caches, RAM, IO); the slave side is the controller.
interface mem_arbiter_ctrl_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_BYTES = 4
);
  logic                    rdy_in;
  logic                    io_full;

  logic                    ic_req;
  logic [31:0]             ic_addr;
  logic                    ic_done;
  logic [LINE_BYTES*8-1:0] ic_data;

  logic                    dc_req;
  logic                    dc_we;
  logic [1:0]              dc_len;
  logic [31:0]             dc_addr;
  logic [31:0]             dc_wdata;
  logic                    dc_done;
  logic [31:0]             dc_rdata;

  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_WIDTH-1:0]   mem_a;
  logic                    mem_wr;

  logic                    busy;

  modport master (
    output rdy_in, io_full,
    output ic_req, ic_addr,
    input  ic_done, ic_data,
    output dc_req, dc_we, dc_len, dc_addr, dc_wdata,
    input  dc_done, dc_rdata,
    output mem_din,
    input  mem_dout, mem_a, mem_wr,
    input  busy
  );

  modport slave (
    input  rdy_in, io_full,
    input  ic_req, ic_addr,
    output ic_done, ic_data,
    input  dc_req, dc_we, dc_len, dc_addr, dc_wdata,
    output dc_done, dc_rdata,
    input  mem_din,
    output mem_dout, mem_a, mem_wr,
    output busy
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial RAM controller arbitrating icache line reads and dcache reads/writes
// onto one 8-bit RAM port, with IO back-pressure and a global stall.
module mem_arbiter_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_ctrl_if.slave bus
);
  localparam int LW = $clog2(LINE_BYTES);
  localparam int DW = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RD,
    S_RD_TAIL,
    S_WR,
    S_DONE
  } state_t;

  state_t                state_q, state_d;

  // Request latched at the grant edge
  logic                  own_ic_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [LW-1:0]         last_q;

  logic [LW-1:0]         cnt_q;
  logic                  pend_q;
  logic [LW-1:0]         lane_q;
  logic [DW-1:0]         buf_q, buf_next;

  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0]         ic_data_q;
  logic [31:0]           dc_rdata_q;

  logic                  grant, grant_dc;
  logic                  active, issue, done_ev;
  logic                  io_wr;
  logic [LW-1:0]         dc_last;

  assign io_wr = we_q && (addr_q[17:16] == 2'b11);

  always_comb begin
    dc_last = LW'(3);
    unique case (bus.dc_len)
      2'd0:    dc_last = '0;
      2'd1:    dc_last = LW'(1);
      default: dc_last = LW'(3);
    endcase
  end

  // Every transition is gated by rdy_in, which is what freezes the whole machine
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_dc = 1'b0;
    active   = 1'b0;
    issue    = 1'b0;
    done_ev  = 1'b0;
    if (bus.rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.dc_req) begin
            grant    = 1'b1;
            grant_dc = 1'b1;
            state_d  = S_GRANT;
          end else if (bus.ic_req) begin
            grant   = 1'b1;
            state_d = S_GRANT;
          end
        end
        S_GRANT: state_d = we_q ? S_WR : S_RD;
        S_RD: begin
          active = 1'b1;
          issue  = 1'b1;
          if (cnt_q == last_q) state_d = S_RD_TAIL;
        end
        S_WR: begin
          active = 1'b1;
          issue  = !(io_wr && bus.io_full);
          if (issue && (cnt_q == last_q)) state_d = S_DONE;
        end
        S_RD_TAIL: state_d = S_DONE;
        S_DONE: begin
          done_ev = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The byte issued in the previous cycle lands in its lane regardless of rdy_in
  always_comb begin
    buf_next = buf_q;
    if (pend_q) buf_next[{lane_q, 3'b000} +: 8] = bus.mem_din;
  end

  assign mem_a_d = active ? ADDR_WIDTH'(addr_q + 32'(cnt_q)) : mem_a_q;

  assign bus.mem_a    = mem_a_d;
  assign bus.mem_wr   = issue && (state_q == S_WR);
  assign bus.mem_dout = (issue && (state_q == S_WR)) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : '0;
  assign bus.ic_done  = done_ev && own_ic_q;
  assign bus.dc_done  = done_ev && !own_ic_q;
  assign bus.ic_data  = ic_data_q;
  assign bus.dc_rdata = dc_rdata_q;
  assign bus.busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_ic_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      lane_q     <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      ic_data_q  <= '0;
      dc_rdata_q <= '0;
    end else begin
      mem_a_q <= mem_a_d;
      pend_q  <= issue && (state_q == S_RD);
      lane_q  <= cnt_q;
      buf_q   <= grant ? '0 : buf_next;

      if (grant) begin
        cnt_q <= '0;
        if (grant_dc) begin
          own_ic_q <= 1'b0;
          we_q     <= bus.dc_we;
          addr_q   <= bus.dc_addr;
          wdata_q  <= bus.dc_wdata;
          last_q   <= dc_last;
        end else begin
          own_ic_q <= 1'b1;
          we_q     <= 1'b0;
          addr_q   <= bus.ic_addr;
          wdata_q  <= '0;
          last_q   <= LW'(LINE_BYTES - 1);
        end
      end else if (issue) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Publish assembled data on the edge into DONE, so it is valid with the pulse
      if ((state_q == S_RD_TAIL) && bus.rdy_in) begin
        if (own_ic_q) ic_data_q  <= buf_next;
        else          dc_rdata_q <= buf_next[31:0];
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: cycle-exact traces with hand-computed values,
// backed by a small byte RAM model with one-cycle read latency.
module tb_mem_arbiter_ctrl;
  localparam int AW = 17;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  mem_arbiter_ctrl_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) bus ();

  mem_arbiter_ctrl #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [int unsigned];

  always @(posedge clk) begin
    if (bus.mem_wr) ram[32'(bus.mem_a)] = bus.mem_dout;
    bus.mem_din <= ram.exists(32'(bus.mem_a)) ? ram[32'(bus.mem_a)] : 8'h00;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic step();
    tick();
    look();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rdy_in   = 1'b1;
    bus.io_full  = 1'b0;
    bus.ic_req   = 1'b0;
    bus.ic_addr  = '0;
    bus.dc_req   = 1'b0;
    bus.dc_we    = 1'b0;
    bus.dc_len   = '0;
    bus.dc_addr  = '0;
    bus.dc_wdata = '0;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h200] = 8'h5A;
    ram[32'h300] = 8'hA0; ram[32'h301] = 8'hA1; ram[32'h302] = 8'hA2; ram[32'h303] = 8'hA3;
    ram[32'h400] = 8'hDE; ram[32'h401] = 8'hAD; ram[32'h402] = 8'hBE; ram[32'h403] = 8'hEF;

    // Reset state
    #2;
    check("rst busy", bus.busy, 0);
    check("rst mem_wr", bus.mem_wr, 0);
    check("rst mem_a", bus.mem_a, 0);
    check("rst mem_dout", bus.mem_dout, 0);
    check("rst dc_done", bus.dc_done, 0);
    check("rst ic_done", bus.ic_done, 0);
    check("rst ic_data", bus.ic_data, 0);
    check("rst dc_rdata", bus.dc_rdata, 0);
    step();
    step();
    tick(); rst = 1'b1; look();
    check("post-rst busy", bus.busy, 0);

    // T1: dc read 4 bytes at 0x100; addr input changed after grant must be ignored
    tick(); bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_len = 2'd2; bus.dc_addr = 32'h100; look();
    check("t1 idle", bus.busy, 0);
    tick(); bus.dc_addr = 32'h0000_DEAD; look();
    check("t1 grant busy", bus.busy, 1);
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      check("t1 mem_a", bus.mem_a, 64'h100 + k);
      check("t1 mem_wr", bus.mem_wr, 0);
    end
    step();
    check("t1 done early", bus.dc_done, 0);
    tick(); bus.dc_req = 1'b0; look();
    check("t1 dc_done", bus.dc_done, 1);
    check("t1 dc_rdata", bus.dc_rdata, 64'h4433_2211);
    step();
    check("t1 done pulse", bus.dc_done, 0);
    check("t1 back idle", bus.busy, 0);

    // T2: dc write 2 bytes at 0x1FFFF wrapping to 0
    tick(); bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_len = 2'd1;
    bus.dc_addr = 32'h1FFFF; bus.dc_wdata = 32'h0000_ABCD; look();
    step();
    step();
    check("t2 a0", bus.mem_a, 64'h1FFFF);
    check("t2 wr0", bus.mem_wr, 1);
    check("t2 d0", bus.mem_dout, 64'hCD);
    step();
    check("t2 a1", bus.mem_a, 0);
    check("t2 wr1", bus.mem_wr, 1);
    check("t2 d1", bus.mem_dout, 64'hAB);
    tick(); bus.dc_req = 1'b0; look();
    check("t2 dc_done", bus.dc_done, 1);
    check("t2 wr off", bus.mem_wr, 0);
    check("t2 dout off", bus.mem_dout, 0);
    step();

    // T3: simultaneous ic and dc requests; dc wins, ic granted two cycles after dc done
    tick(); bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_len = 2'd0; bus.dc_addr = 32'h200;
    bus.ic_req = 1'b1; bus.ic_addr = 32'h300; look();
    step();
    step();
    check("t3 dc first", bus.mem_a, 64'h200);
    step();
    tick(); bus.dc_req = 1'b0; look();
    check("t3 dc_done", bus.dc_done, 1);
    check("t3 no ic_done", bus.ic_done, 0);
    check("t3 dc_rdata", bus.dc_rdata, 64'h5A);
    step();
    check("t3 idle gap", bus.busy, 0);
    step();
    check("t3 ic grant", bus.busy, 1);
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      check("t3 ic mem_a", bus.mem_a, 64'h300 + k);
    end
    step();
    check("t3 ic early", bus.ic_done, 0);
    tick(); bus.ic_req = 1'b0; look();
    check("t3 ic_done", bus.ic_done, 1);
    check("t3 ic_data", bus.ic_data, 64'hA3A2_A1A0);
    check("t3 dc hold", bus.dc_rdata, 64'h5A);
    check("t3 dc quiet", bus.dc_done, 0);
    step();

    // T4: IO write at 0x30000 throttled by io_full for three cycles
    tick(); bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_len = 2'd0;
    bus.dc_addr = 32'h30000; bus.dc_wdata = 32'h0000_0077; look();
    step();
    for (int unsigned k = 0; k < 3; k++) begin
      tick(); bus.io_full = 1'b1; look();
      check("t4 throttled wr", bus.mem_wr, 0);
      check("t4 throttled dout", bus.mem_dout, 0);
    end
    tick(); bus.io_full = 1'b0; look();
    check("t4 wr", bus.mem_wr, 1);
    check("t4 a", bus.mem_a, 64'h10000);
    check("t4 dout", bus.mem_dout, 64'h77);
    check("t4 done early", bus.dc_done, 0);
    tick(); bus.dc_req = 1'b0; look();
    check("t4 dc_done", bus.dc_done, 1);
    step();

    // T5: global stall for two cycles right after byte 1 of a read is issued
    tick(); bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_len = 2'd3; bus.dc_addr = 32'h400; look();
    step();
    step();
    check("t5 a0", bus.mem_a, 64'h400);
    step();
    check("t5 a1", bus.mem_a, 64'h401);
    for (int unsigned k = 0; k < 2; k++) begin
      tick(); bus.rdy_in = 1'b0; look();
      check("t5 stall a hold", bus.mem_a, 64'h401);
      check("t5 stall busy", bus.busy, 1);
    end
    tick(); bus.rdy_in = 1'b1; look();
    check("t5 a2", bus.mem_a, 64'h402);
    step();
    check("t5 a3", bus.mem_a, 64'h403);
    step();
    check("t5 done early", bus.dc_done, 0);
    tick(); bus.dc_req = 1'b0; look();
    check("t5 dc_done", bus.dc_done, 1);
    check("t5 dc_rdata", bus.dc_rdata, 64'hEFBE_ADDE);
    step();

    // T6: reset pulsed in the middle of a write
    tick(); bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_len = 2'd2;
    bus.dc_addr = 32'h500; bus.dc_wdata = 32'h1122_3344; look();
    step();
    step();
    check("t6 d0", bus.mem_dout, 64'h44);
    step();
    check("t6 wr1", bus.mem_wr, 1);
    rst = 1'b0;
    #1;
    check("t6 rst wr", bus.mem_wr, 0);
    check("t6 rst busy", bus.busy, 0);
    check("t6 rst a", bus.mem_a, 0);
    check("t6 rst dc_rdata", bus.dc_rdata, 0);
    check("t6 rst ic_data", bus.ic_data, 0);
    tick(); bus.dc_req = 1'b0; look();
    check("t6 no done", bus.dc_done, 0);
    tick(); rst = 1'b1; look();
    check("t6 idle", bus.busy, 0);
    step();
    check("t6 still no done", bus.dc_done, 0);

    // Read back 2 bytes: only byte 0 of the aborted write reached RAM
    tick(); bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_len = 2'd1; bus.dc_addr = 32'h500; look();
    step();
    step();
    check("t6 rb a0", bus.mem_a, 64'h500);
    step();
    check("t6 rb a1", bus.mem_a, 64'h501);
    step();
    tick(); bus.dc_req = 1'b0; look();
    check("t6 rb done", bus.dc_done, 1);
    check("t6 rb data", bus.dc_rdata, 64'h0044);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Byte-serial RAM controller that sits between the instruction cache, the data cache and the single 8-bit RAM port. It arbitrates between the two client channels and serialises each request into 1 to LINE_BYTES byte accesses. It assembles read data little-endian and returns it with a one-cycle done pulse. Relative to the first-generation controller, it adds writes, variable request lengths, a parametrised icache line burst, IO-space back-pressure and a global stall.

## Interface
- ADDR_WIDTH, 17: width of the RAM address bus.
- LINE_BYTES, 4: icache burst length in bytes; a power of two in the range 4..64.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; 0 stalls the controller.
- io_full  in  1  IO write buffer full.
- ic_req  in  1  icache line-read request, level; held until ic_done.
- ic_addr  in  32  line base address.
- ic_done  out  1  one-cycle pulse; ic_data is valid in the same cycle.
- ic_data  out  LINE_BYTES*8  line data; byte k sits at bits [8k+7:8k].
- dc_req  in  1  dcache request, level; held until dc_done.
- dc_we  in  1  1 = write, 0 = read.
- dc_len  in  2  transfer size: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
- dc_addr  in  32  byte address.
- dc_wdata  in  32  write data, little-endian.
- dc_done  out  1  one-cycle pulse.
- dc_rdata  out  32  read data, zero-extended.
- mem_din  in  8  RAM read data; valid 1 cycle after its address.
- mem_dout  out  8  RAM write data.
- mem_a  out  ADDR_WIDTH  RAM address.
- mem_wr  out  1  RAM write strobe.
- busy  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → GRANT on a request.
  - GRANT → RD or WR.
  - RD → RD_TAIL after the last address is issued.
  - RD_TAIL → DONE once the last byte is captured.
  - WR → DONE after the last byte is written.
  - DONE → IDLE.
- Arbitration in IDLE: dc has fixed priority over ic. The winner's addr, we, len and wdata are latched at the grant edge; later changes to the inputs are ignored.
- Byte count N: 1, 2 or 4 from dc_len; LINE_BYTES for ic.
- Address for byte k (k = 0..N-1): (addr + k) computed in 32 bits, truncated to ADDR_WIDTH. Wrap-around at 2^ADDR_WIDTH is natural and not an error.
- Read: byte k's address is issued in issue cycle k. mem_din is captured in the following cycle into byte lane k. Untouched lanes of dc_rdata read 0.
- Write: issue cycle k drives mem_a = addr+k, mem_dout = dc_wdata[8k+7:8k], mem_wr = 1.
- IO space is addr[17:16] == 2'b11. For an IO write, any cycle with io_full = 1 drives mem_wr = 0 and holds the byte counter. IO reads are not throttled.
- rdy_in = 0:
  - State and counters freeze; mem_wr is forced to 0; mem_a holds its value.
  - A byte issued in the cycle before the stall is still captured in the first stalled cycle.
  - Issuing resumes at the next unissued byte.
- DONE state: the winner's done pulses high for one cycle; the data outputs hold until the next done.
- Requests are ignored in DONE. A client still asserting req in DONE is re-granted from IDLE, so clients must drop req on done.
- Outside a write issue cycle, mem_wr = 0 and mem_dout = 0.

## Timing
- Reset (rst low, asynchronous, takes effect immediately):
  - State returns to IDLE and all counters clear.
  - Every output goes to 0: mem_wr, mem_a, mem_dout, ic_done, dc_done, ic_data, dc_rdata, busy.
  - A transfer in progress is aborted without a done.
- Grant edge is G. With no stalls:
  - Issue cycles are G+1 .. G+N.
  - A read's done is high in cycle G+N+2.
  - A write's done is high in cycle G+N+1.
- The earliest next grant is 2 cycles after done (DONE → IDLE → GRANT).
- Simultaneous ic_req and dc_req in IDLE: dc is granted and ic waits; ic is granted on the first IDLE cycle in which dc_req = 0.
- A request arriving while busy waits; it is never dropped.
- Stall cycles (rdy_in = 0 or io_full throttling) add exactly one cycle each to the latency.

## Test plan
- dc read, len = 2, addr 0x100, RAM bytes 11 22 33 44 → mem_a = 100,101,102,103 in cycles G+1..G+4; dc_rdata = 0x44332211 with dc_done in G+6.
- dc write, len = 1, addr 0x1FFFF, wdata 0xABCD → bytes CD at 0x1FFFF, then AB at 0x00000 (wrap); mem_wr high 2 cycles; dc_done in G+3.
- ic_req and dc_req asserted in the same cycle, LINE_BYTES = 4 → dc served first; ic grant follows 2 cycles after dc_done; ic_data holds the 4 line bytes.
- IO write to 0x30000 with io_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then writes 1 byte; dc_done is 3 cycles later than unstalled.
- rdy_in low for 2 cycles mid-read after byte 1 is issued → byte 1 still captured, byte 2 issues after resume, data correct, latency +2.
- rst pulsed low mid-write → mem_wr drops to 0 immediately; no done; next request behaves as from reset.
